// File: rtl/seg_pkg.sv
// seg_pkg: shared types and default constants for the seven-segment scan
// controller (seg_scan_ctrl) and its slot timer (seg_slot_timer).
//   seg_state_t   : scan FSM state (BLANK gap, SHOW digit)
//   SEG_DIGITS    : default number of scanned digits
//   SEG_PRESCALE  : default clk cycles per digit slot (blank + show)
//   SEG_BLANK_CYC : default blank cycles at the start of each slot
//   SEG_NIB_W     : width of one hex digit
package seg_pkg;

    localparam int SEG_DIGITS    = 8;
    localparam int SEG_PRESCALE  = 100000;
    localparam int SEG_BLANK_CYC = 4;
    localparam int SEG_NIB_W     = 4;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } seg_state_t;

endpackage

// File: rtl/seg_slot_timer.sv
// seg_slot_timer: prescaler for the digit scan. Owns the in-slot cycle
// counter cnt (0..PRESCALE-1) and the digit index idx (0..DIGITS-1).
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   blank_end  : high during the last blank cycle of a slot
//   slot_end   : high during the last cycle of a slot
//   frame_end  : high during the last cycle of the last digit's slot
//   idx        : digit currently being scanned
// Strobes are combinational decodes of the registered counters, so the
// consumer acts on them at the same edge that wraps or advances them.
module seg_slot_timer
    import seg_pkg::*;
#(
    parameter int DIGITS    = SEG_DIGITS,
    parameter int PRESCALE  = SEG_PRESCALE,
    parameter int BLANK_CYC = SEG_BLANK_CYC,
    localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             blank_end,
    output logic             slot_end,
    output logic             frame_end,
    output logic [IDX_W-1:0] idx
);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0] cnt;

    assign blank_end = (cnt == BLANK_LAST);
    assign slot_end  = (cnt == SLOT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= frame_end ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a shared seven-segment
// decoder driving a common-segment digit array.
// Ports:
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   load_valid   : producer offers a frame (load_data/load_point/load_en)
//   load_ready   : controller can accept a frame (pending slot empty)
//   load_data    : DIGITS hex nibbles, nibble i at [4i+3:4i], digit 0 rightmost
//   load_point   : decimal point per digit
//   load_en      : 1 = digit shown, 0 = digit blanked through LE
//   dec_data     : nibble to the decoder
//   dec_point    : point to the decoder
//   dec_le       : decoder blank, 1 turns all segments off
//   an           : active-low anode select, at most one bit low
//   frame_done   : one-cycle pulse after the last digit's slot ends
//   dbg_state    : current scan FSM state (0 = BLANK, 1 = SHOW)
// Build option: define SEG_SCAN_LZS_EN for leading-zero suppression.
//
// Load handshake: a frame transfers on a rising edge where load_valid and
// load_ready are both high. load_ready is simply "pending slot empty", so the
// producer may hold load_valid high; exactly one frame moves per ready window.
// An accepted frame waits in the pending slot and is copied to the active
// frame at the frame_end edge, so a frame is never changed mid-scan.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS    = SEG_DIGITS,
    parameter int PRESCALE  = SEG_PRESCALE,
    parameter int BLANK_CYC = SEG_BLANK_CYC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [SEG_NIB_W*DIGITS-1:0] load_data,
    input  logic [DIGITS-1:0]        load_point,
    input  logic [DIGITS-1:0]        load_en,
    output logic [SEG_NIB_W-1:0]     dec_data,
    output logic                     dec_point,
    output logic                     dec_le,
    output logic [DIGITS-1:0]        an,
    output logic                     frame_done,
    output logic                     dbg_state
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    seg_state_t state;

    logic                        blank_end;
    logic                        slot_end;
    logic                        frame_end;
    logic [IDX_W-1:0]            idx;

    logic [SEG_NIB_W*DIGITS-1:0] act_data;
    logic [DIGITS-1:0]           act_point;
    logic [DIGITS-1:0]           act_en;
    // Set by the first commit; until then SHOW slots keep the anodes off so
    // an idle controller leaves the display completely dark.
    logic                        act_valid;

    logic [SEG_NIB_W*DIGITS-1:0] pend_data;
    logic [DIGITS-1:0]           pend_point;
    logic [DIGITS-1:0]           pend_en;
    logic                        pend_valid;

    logic                        xfer;
    logic [SEG_NIB_W-1:0]        cur_nib;
    logic                        cur_point;
    logic                        cur_en;
    logic                        suppress;

    seg_slot_timer #(
        .DIGITS    (DIGITS),
        .PRESCALE  (PRESCALE),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .blank_end (blank_end),
        .slot_end  (slot_end),
        .frame_end (frame_end),
        .idx       (idx)
    );

    assign load_ready = ~pend_valid;
    assign xfer       = load_valid && load_ready;
    assign dbg_state  = state;

    // Select the active digit's fields for the current index.
    always_comb begin
        cur_nib   = '0;
        cur_point = 1'b0;
        cur_en    = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib   = act_data[i*SEG_NIB_W +: SEG_NIB_W];
                cur_point = act_point[i];
                cur_en    = act_en[i];
            end
        end
    end

`ifdef SEG_SCAN_LZS_EN
    // upper_zero[i] is high when nibbles i..DIGITS-1 are all zero; built
    // from the most significant digit downwards.
    logic [DIGITS-1:0] upper_zero;
    logic              lz_acc;

    always_comb begin
        upper_zero = '0;
        lz_acc     = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lz_acc        = lz_acc & (act_data[i*SEG_NIB_W +: SEG_NIB_W] == '0);
            upper_zero[i] = lz_acc;
        end
    end

    // Digit 0 always shows so a zero value still displays "0".
    assign suppress = (idx != '0) && upper_zero[idx];
`else
    assign suppress = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BLANK;
            an         <= '1;
            dec_le     <= 1'b1;
            dec_data   <= '0;
            dec_point  <= 1'b0;
            frame_done <= 1'b0;
            act_data   <= '0;
            act_point  <= '0;
            act_en     <= '0;
            act_valid  <= 1'b0;
            pend_data  <= '0;
            pend_point <= '0;
            pend_en    <= '0;
            pend_valid <= 1'b0;
        end else begin
            frame_done <= frame_end;

            // Outputs are loaded together with the state change so the
            // anode pattern always matches the registered state.
            case (state)
                BLANK: begin
                    if (blank_end) begin
                        state <= SHOW;
                        if (act_valid) begin
                            an        <= ~(DIGITS'(1) << idx);
                            dec_data  <= cur_nib;
                            dec_point <= cur_point;
                            dec_le    <= ~cur_en | suppress;
                        end
                    end
                end
                SHOW: begin
                    if (slot_end) begin
                        state  <= BLANK;
                        an     <= '1;
                        dec_le <= 1'b1;
                    end
                end
                default: begin
                    state  <= BLANK;
                    an     <= '1;
                    dec_le <= 1'b1;
                end
            endcase

            // Commit and accept are exclusive: xfer needs pend_valid low.
            if (frame_end && pend_valid) begin
                act_data   <= pend_data;
                act_point  <= pend_point;
                act_en     <= pend_en;
                act_valid  <= 1'b1;
                pend_valid <= 1'b0;
            end else if (xfer) begin
                pend_data  <= load_data;
                pend_point <= load_point;
                pend_en    <= load_en;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl with DIGITS=4,
// PRESCALE=8, BLANK_CYC=2. A reference model tracks frame timing and the
// frame registers and pushes one expected record per displayed digit slot;
// a negedge monitor pops and compares each SHOW phase the DUT presents.
module tb_seg_scan_ctrl;

    localparam int DIGITS    = 4;
    localparam int PRESCALE  = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = DIGITS * PRESCALE;
    localparam int SHOW_CYC  = PRESCALE - BLANK_CYC;
    localparam int W         = 10;  // {an[3:0], data[3:0], point, le}

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  load_point;
    logic [3:0]  load_en;
    logic [3:0]  dec_data;
    logic        dec_point;
    logic        dec_le;
    logic [3:0]  an;
    logic        frame_done;
    logic        dbg_state;

    seg_scan_ctrl #(
        .DIGITS    (DIGITS),
        .PRESCALE  (PRESCALE),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_point (load_point),
        .load_en    (load_en),
        .dec_data   (dec_data),
        .dec_point  (dec_point),
        .dec_le     (dec_le),
        .an         (an),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int errors   = 0;
    int n_popped = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- reference model (updates at each rising edge) ----------------
    int          mcnt     = 0;
    logic        m_pv     = 1'b0;
    logic        m_av     = 1'b0;
    logic [15:0] m_pd     = '0;
    logic [15:0] m_ad     = '0;
    logic [3:0]  m_pp     = '0;
    logic [3:0]  m_ap     = '0;
    logic [3:0]  m_pe     = '0;
    logic [3:0]  m_ae     = '0;
    logic        m_fd_exp = 1'b0;
    logic        m_in_rst = 1'b1;

    task automatic push_frame();
        logic [3:0] one;
        logic [3:0] e_an;
        logic [3:0] e_nib;
        logic       e_le;
        one = 4'b0001;
        for (int i = 0; i < DIGITS; i++) begin
            e_an  = ~(one << i);
            e_nib = m_ad[i*4 +: 4];
            e_le  = ~m_ae[i];
`ifdef SEG_SCAN_LZS_EN
            if (i > 0 && (m_ad >> (4 * i)) == 16'h0) e_le = 1'b1;
`endif
            exp_q.push_back({e_an, e_nib, m_ap[i], e_le});
        end
    endtask

    always @(posedge clk) begin
        logic xfer;
        logic fend;
        if (rst) begin
            mcnt     = 0;
            m_pv     = 1'b0;
            m_av     = 1'b0;
            m_ad     = '0;
            m_ap     = '0;
            m_ae     = '0;
            m_fd_exp = 1'b0;
            m_in_rst = 1'b1;
            exp_q.delete();
        end else begin
            m_in_rst = 1'b0;
            xfer     = load_valid && !m_pv;
            fend     = (mcnt == FRAME - 1);
            mcnt     = fend ? 0 : mcnt + 1;
            m_fd_exp = fend;
            if (fend && m_pv) begin
                m_ad = m_pd;
                m_ap = m_pp;
                m_ae = m_pe;
                m_av = 1'b1;
                m_pv = 1'b0;
            end
            if (fend && m_av) push_frame();
            if (xfer) begin
                m_pd = load_data;
                m_pp = load_point;
                m_pe = load_en;
                m_pv = 1'b1;
            end
        end
    end

    // ---------------- monitor (samples on falling edge) ----------------
    logic         in_phase  = 1'b0;
    logic         have_prev = 1'b0;
    int           ph_len    = 0;
    int           gap_len   = 0;
    logic [W-1:0] ph_val    = '0;

    always @(negedge clk) begin
        logic [W-1:0] cur;
        logic [W-1:0] exp;
        cur = {an, dec_data, dec_point, dec_le};
        if (m_in_rst) begin
            chk("rst_an", 32'(an), 32'hF);
            chk("rst_le", 32'(dec_le), 32'h1);
            chk("rst_data", 32'(dec_data), 32'h0);
            chk("rst_point", 32'(dec_point), 32'h0);
            chk("rst_frame_done", 32'(frame_done), 32'h0);
            chk("rst_ready", 32'(load_ready), 32'h1);
            in_phase  = 1'b0;
            have_prev = 1'b0;
            ph_len    = 0;
            gap_len   = 0;
        end else begin
            chk("frame_done", 32'(frame_done), 32'(m_fd_exp));
            chk("load_ready", 32'(load_ready), 32'(!m_pv));
            if ($countones(~an) > 1) fail_now("an_multi_low");
            if (an != 4'hF) begin
                if (!in_phase) begin
                    in_phase = 1'b1;
                    ph_len   = 1;
                    ph_val   = cur;
                    if (have_prev) chk("blank_gap", 32'(gap_len), 32'(BLANK_CYC));
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_show");
                    end else begin
                        exp = exp_q.pop_front();
                        n_popped++;
                        chk("slot_an_data_pt_le", 32'(cur), 32'(exp));
                    end
                end else begin
                    ph_len++;
                    if (cur != ph_val) chk("show_stable", 32'(cur), 32'(ph_val));
                end
            end else begin
                if (dec_le !== 1'b1) chk("blank_le", 32'(dec_le), 32'h1);
                if (in_phase) begin
                    chk("show_len", 32'(ph_len), 32'(SHOW_CYC));
                    in_phase  = 1'b0;
                    have_prev = 1'b1;
                    gap_len   = 1;
                end else begin
                    gap_len++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_frame(input logic [15:0] d, input logic [3:0] p,
                              input logic [3:0] e, input bit hold);
        int budget;
        bit done;
        @(negedge clk);
        load_data  = d;
        load_point = p;
        load_en    = e;
        load_valid = 1'b1;
        done       = 1'b0;
        budget     = 0;
        while (!done && budget < 200) begin
            if (load_ready) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
                budget++;
            end
        end
        if (!done) fail_now("load_timeout");
        if (!hold) begin
            @(negedge clk);
            load_valid = 1'b0;
        end
    endtask

    task automatic wait_mcnt(input int v);
        int budget;
        budget = 0;
        @(negedge clk);
        while (mcnt != v && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (mcnt != v) fail_now("wait_mcnt_timeout");
    endtask

    // ---------------- watchdog ----------------
    initial begin
        repeat (20000) @(posedge clk);
        fail_now("watchdog");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        load_point = '0;
        load_en    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: dark display, frame_done every FRAME cycles.
        repeat (70) @(negedge clk);

        // Basic frame with a point on digit 2.
        wait_mcnt(5);
        load_frame(16'h1A3F, 4'b0100, 4'b1111, 1'b0);
        repeat (2 * FRAME + 10) @(negedge clk);

        // Back-to-back loads with load_valid held high.
        wait_mcnt(5);
        load_frame(16'h1111, 4'b0000, 4'b1111, 1'b1);
        load_frame(16'h2222, 4'b0000, 4'b1111, 1'b0);
        repeat (3 * FRAME) @(negedge clk);

        // Per-digit enables.
        wait_mcnt(5);
        load_frame(16'h1234, 4'b0000, 4'b0101, 1'b0);
        repeat (2 * FRAME) @(negedge clk);

        // Leading zeros (suppressed only in the LZS build).
        wait_mcnt(5);
        load_frame(16'h0030, 4'b0000, 4'b1111, 1'b0);
        repeat (2 * FRAME) @(negedge clk);

        // Reset during slot 2 SHOW with a frame pending.
        wait_mcnt(2);
        load_frame(16'h5555, 4'b1111, 4'b1111, 1'b0);
        wait_mcnt(19);
        chk("pre_rst_an", 32'(an), 32'hB);
        chk("pre_rst_ready", 32'(load_ready), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_an", 32'(an), 32'hF);
        chk("post_rst_ready", 32'(load_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * FRAME + 10) @(negedge clk);

        chk("slots_seen_min", 32'(n_popped >= 32), 32'h1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the shared seven-segment decoder (4-bit data, point, LE blank inputs) on the board's common-segment digit array.
- Holds a frame of hex nibbles, point bits and digit enables.
- Steps one digit at a time with a blanking gap between digits, which stops ghosting.
- Drives the active-low anodes.
- New frames arrive over a valid/ready handshake and take effect only at a frame boundary, so the display never tears.

Parameters:
- DIGITS, 8: number of digits scanned.
- PRESCALE, 100000: clk cycles per digit slot, blank plus show; legal range is greater than BLANK_CYC.
- BLANK_CYC, 4: cycles at the start of each slot with all anodes off and LE=1; legal range is at least 1.

Ports:
- clk, input, 1: system clock; everything is rising-edge.
- rst, input, 1: synchronous active-high reset.
- load_valid, input, 1: the producer offers a new frame.
- load_ready, output, 1: the controller can accept a frame.
- load_data, input, 4*DIGITS: nibble i is bits [4i+3:4i]; digit 0 is the rightmost.
- load_point, input, DIGITS: point bit per digit, passed to the decoder unchanged.
- load_en, input, DIGITS: 1 means the digit is shown, 0 means it is blanked via LE.
- dec_data, output, 4: nibble to the decoder.
- dec_point, output, 1: point to the decoder.
- dec_le, output, 1: decoder blank; 1 turns all segments off.
- an, output, DIGITS: anode select, active-low, at most one bit low.
- frame_done, output, 1: one-cycle pulse when the last digit's slot ends.

Behaviour:
- Reset values:
  - an all 1s, dec_le=1, dec_data=0, dec_point=0, frame_done=0, load_ready=1.
  - Slot counter 0, digit index 0, state BLANK.
  - Active and pending frame registers are 0, so all digits are disabled.
- Outputs are registered and update on the clk edge after the state/counter change.
- Two-deep storage:
  - The active frame drives the display; the pending frame holds an accepted load.
  - load_ready = not pending_valid.
  - Handshake: a transfer occurs when load_valid && load_ready at a rising edge. Data is captured into pending and pending_valid is set.
  - load_valid may stay high; only one transfer occurs per ready window.
- State machine, counter cnt counting 0..PRESCALE-1 per slot:
  - BLANK:
    - Outputs: an all 1s, dec_le=1.
    - cnt increments.
    - When cnt==BLANK_CYC-1, go to SHOW.
  - SHOW:
    - Outputs: an[idx]=0, others 1; dec_data=active nibble idx; dec_point=active point idx; dec_le=~active_en[idx].
    - When cnt==PRESCALE-1: cnt goes to 0, the state goes to BLANK, and idx advances.
  - idx wrap:
    - On the slot end with idx==DIGITS-1, idx goes to 0 and frame_done pulses for exactly one cycle.
    - If pending_valid, the pending frame is copied to the active frame and pending_valid clears in that same edge (commit).
    - The new frame is first visible in slot 0 of the next frame.
- Simultaneous events:
  - A load handshake cannot coincide with a commit, because ready=0 while pending.
  - A load accepted on the commit edge itself, with pending empty beforehand, becomes pending and is committed at the next frame end.
- Timing:
  - The first SHOW begins BLANK_CYC cycles after rst deasserts.
  - Frame period is DIGITS*PRESCALE cycles.
- Reset mid-operation:
  - rst takes effect on the next edge regardless of state.
  - The pending frame is discarded and the display blanks immediately; no frame_done pulse.
- Invariant: an never has more than one 0 bit, and an is all 1s whenever dec_le is forced by BLANK.

Optional Feature:
- Macro SEG_SCAN_LZS_EN, leading-zero suppression.
- When defined: in SHOW, digit idx>0 is blanked (dec_le=1) if every active nibble from idx up to DIGITS-1 is 0, even when its enable is 1. Digit 0 is never suppressed.
- When undefined: only active_en controls blanking.
- Suppression does not change the an pattern, the handshake or frame timing.

Decomposition:
- Package seg_pkg:
  - State enum (BLANK, SHOW).
  - Default constants SEG_DIGITS, SEG_PRESCALE, SEG_BLANK_CYC.
  - Nibble width constant 4.
- Sub-module seg_slot_timer: the prescaler owning cnt and idx. It outputs blank_end, slot_end and frame_end strobes.
- The top level holds the FSM, the frame registers, the handshake and the output muxing.

Test Plan:
Bench uses DIGITS=4, PRESCALE=8, BLANK_CYC=2.
1. Reset, no load: an stays 4'b1111 and dec_le stays 1 forever; frame_done pulses every 32 cycles, first at cycle 31 after rst drops.
2. Load data=16'h1A3F, point=4'b0100, en=4'b1111 during the first frame:
   - Nothing shows until frame_done.
   - Next frame: slot 0 gives an=1110, data=F; slot 1 gives an=1101, data=3; slot 2 gives an=1011, data=A, point=1; slot 3 gives an=0111, data=1.
   - Each slot is 2 blank cycles then 6 show cycles.
3. Back-to-back loads 16'h1111 then 16'h2222 with load_valid held high:
   - The second load is accepted only on the cycle after the commit edge.
   - Displayed frames are 1111, then 2222.
4. en=4'b0101, data=16'h1234: digits 1 and 3 have their anode low while dec_le=1; digits 0 and 2 show 4 and 2.
5. With SEG_SCAN_LZS_EN, data=16'h0030, en=4'b1111: digits 3 and 2 are blanked, digit 1 shows 3, digit 0 shows 0. Without the macro, all four digits show.
6. Assert rst during slot 2 SHOW with a frame pending:
   - Next edge: an=1111, dec_le=1, load_ready=1.
   - The pending frame is never displayed.
